// File: rtl/cache_flush_ctrl_pkg.sv
// Shared cache-subsystem definitions for the flush controller.
// Contents:
//   FlushTimeoutDefault - default number of cycles to wait for a D$ flush ack
//   flush_state_e       - flush controller FSM states
//   flush_job_e         - kind of flush job latched at request time
package cache_flush_ctrl_pkg;

  localparam int unsigned FlushTimeoutDefault = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WB,
    FLUSH_D,
    FLUSH_I,
    DONE
  } flush_state_e;

  typedef enum logic {
    FENCE,
    FENCE_I
  } flush_job_e;

endpackage

// File: rtl/cache_flush_ctrl.sv
// Cache flush sequencer for fence / fence.i.
// Waits for the D$ write buffer to drain, holds a level flush request to the
// cache subsystem until it acks (or a timeout expires), optionally pulses an
// I$ invalidate, then returns a one-cycle ack to the requester.
// Ports:
//   clk_i, rst_ni        - clock, async active-low reset
//   fence_req_i/ack_o    - D$ flush request (level) / completion pulse
//   fence_i_req_i/ack_o  - D$+I$ flush request (level) / completion pulse
//   wbuffer_empty_i      - D$ write path drained
//   dcache_flush_o       - level flush request, high only in FLUSH_D
//   dcache_flush_ack_i   - flush-done pulse, honoured only in FLUSH_D
//   icache_flush_o       - one-cycle I$ invalidate pulse
//   busy_o               - high in every state except IDLE
//   timeout_o            - sticky flush-timeout error, cleared only by reset
//   flush_cnt_o          - completed D$ flushes, wraps modulo 2^CntWidth
//
// state   | meaning
// IDLE    | waiting for a fence or fence.i request
// WAIT_WB | job latched, waiting for the write buffer to drain
// FLUSH_D | dcache_flush_o asserted, waiting for ack or timeout
// FLUSH_I | one-cycle I$ invalidate (fence.i only)
// DONE    | one-cycle ack of the latched job
module cache_flush_ctrl
  import cache_flush_ctrl_pkg::*;
#(
  parameter int unsigned TimeoutCycles = FlushTimeoutDefault,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fence_req_i,
  output logic                fence_ack_o,
  input  logic                fence_i_req_i,
  output logic                fence_i_ack_o,
  input  logic                wbuffer_empty_i,
  output logic                dcache_flush_o,
  input  logic                dcache_flush_ack_i,
  output logic                icache_flush_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [CntWidth-1:0] flush_cnt_o
);

  localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  flush_state_e        state_q, state_d;
  flush_job_e          job_q, job_d;
  logic                both_q, both_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                timeout_q, timeout_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      job_q     <= FENCE;
      both_q    <= 1'b0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      both_q    <= both_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    job_d          = job_q;
    both_d         = both_q;
    tmo_cnt_d      = tmo_cnt_q;
    timeout_d      = timeout_q;
    cnt_d          = cnt_q;
    dcache_flush_o = 1'b0;
    icache_flush_o = 1'b0;
    fence_ack_o    = 1'b0;
    fence_i_ack_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fence_req_i || fence_i_req_i) begin
          state_d = WAIT_WB;
          job_d   = fence_i_req_i ? FENCE_I : FENCE;
          // fence.i covers a simultaneous fence, so both get acked together
          both_d  = fence_req_i && fence_i_req_i;
        end
      end
      WAIT_WB: begin
        if (wbuffer_empty_i) begin
          state_d   = FLUSH_D;
          tmo_cnt_d = '0;
        end
      end
      FLUSH_D: begin
        dcache_flush_o = 1'b1;
        tmo_cnt_d      = tmo_cnt_q + TmoW'(1);
        // an ack on the final allowed cycle still counts as success
        if (dcache_flush_ack_i) begin
          cnt_d   = cnt_q + CntWidth'(1);
          state_d = (job_q == FENCE_I) ? FLUSH_I : DONE;
        end else if (tmo_cnt_q == TmoLast) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      FLUSH_I: begin
        icache_flush_o = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        fence_ack_o   = (job_q == FENCE) || both_q;
        fence_i_ack_o = (job_q == FENCE_I);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = timeout_q;
  assign flush_cnt_o = cnt_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
module tb_cache_flush_ctrl;

  localparam int Tmo = 16;
  localparam int CW  = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic fence_req_i = 1'b0;
  logic fence_i_req_i = 1'b0;
  logic wbuffer_empty_i = 1'b1;
  logic dcache_flush_ack_i = 1'b0;
  logic fence_ack_o, fence_i_ack_o, dcache_flush_o, icache_flush_o, busy_o, timeout_o;
  logic [CW-1:0] flush_cnt_o;

  cache_flush_ctrl #(.TimeoutCycles(Tmo), .CntWidth(CW)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .fence_req_i        (fence_req_i),
    .fence_ack_o        (fence_ack_o),
    .fence_i_req_i      (fence_i_req_i),
    .fence_i_ack_o      (fence_i_ack_o),
    .wbuffer_empty_i    (wbuffer_empty_i),
    .dcache_flush_o     (dcache_flush_o),
    .dcache_flush_ack_i (dcache_flush_ack_i),
    .icache_flush_o     (icache_flush_o),
    .busy_o             (busy_o),
    .timeout_o          (timeout_o),
    .flush_cnt_o        (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // wb: cycles the write buffer stays non-empty; ad: FLUSH_D cycle index on
  // which ack is given (-1 = never); e_*: expected events for the job
  typedef struct {
    bit fence; bit fence_i; int wb; int ad;
    int e_fa; int e_fia; int e_ip; int e_dc; int e_lat; int e_tmo; int e_inc;
  } vec_t;

  typedef struct {
    int fa; int fia; int ip; int dc; int lat; int first_d; int tmo; int cnt;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [CW-1:0] cnt_model = '0;
  int tmo_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    exp_t e, got;
    int cyc, dc, ip, fa, fia, fa_c, fia_c, first_d, wcnt, nbusy;
    bit done;
    e.fa = v.e_fa; e.fia = v.e_fia; e.ip = v.e_ip; e.dc = v.e_dc; e.lat = v.e_lat;
    e.first_d = ((v.wb > 1) ? v.wb : 1) + 1;
    if (v.e_tmo != 0) tmo_model = 1;
    e.tmo = tmo_model;
    if (v.e_inc != 0) cnt_model = cnt_model + 1'b1;
    e.cnt = int'(cnt_model);
    exp_q.push_back(e);

    @(negedge clk_i);
    fence_req_i = v.fence; fence_i_req_i = v.fence_i;
    wbuffer_empty_i = (v.wb == 0); dcache_flush_ack_i = 1'b0;
    cyc = 0; dc = 0; ip = 0; fa = 0; fia = 0; fa_c = -1; fia_c = -1;
    first_d = 0; wcnt = 0; nbusy = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk_i); cyc++;
      dcache_flush_ack_i = 1'b0;
      if (!busy_o) nbusy++;
      if (dcache_flush_o) begin
        if (first_d == 0) first_d = cyc;
        if (dc == v.ad) dcache_flush_ack_i = 1'b1;
        dc++;
      end else if (first_d == 0 && busy_o) begin
        wcnt++;
        if (wcnt >= v.wb) wbuffer_empty_i = 1'b1;
      end
      if (icache_flush_o) ip++;
      if (fence_ack_o) begin fa++; fa_c = cyc; end
      if (fence_i_ack_o) begin fia++; fia_c = cyc; end
      if (fence_ack_o || fence_i_ack_o) begin
        done = 1; fence_req_i = 1'b0; fence_i_req_i = 1'b0;
      end
    end
    if (!done) chk({tag, " ack_seen"}, 0, 1);
    repeat (2) begin
      @(negedge clk_i);
      if (fence_ack_o) fa++;
      if (fence_i_ack_o) fia++;
      if (dcache_flush_o) dc++;
      if (icache_flush_o) ip++;
    end

    got = exp_q.pop_front();
    chk({tag, " fence_ack_count"}, fa, got.fa);
    chk({tag, " fence_i_ack_count"}, fia, got.fia);
    chk({tag, " icache_pulses"}, ip, got.ip);
    chk({tag, " dflush_cycles"}, dc, got.dc);
    chk({tag, " dflush_first_cycle"}, first_d, got.first_d);
    if (got.fa != 0) chk({tag, " fence_ack_latency"}, fa_c, got.lat);
    if (got.fia != 0) chk({tag, " fence_i_ack_latency"}, fia_c, got.lat);
    chk({tag, " idle_while_busy"}, nbusy, 0);
    chk({tag, " timeout"}, timeout_o, got.tmo);
    chk({tag, " flush_cnt"}, flush_cnt_o, got.cnt);
  endtask

  initial begin
    vec_t w;
    int acks, busies;
    //           fe   fi   wb  ad  fa fia ip  dc lat tmo inc
    vecs[0] = '{1'b1, 1'b0, 0,  0, 1, 0, 0,  1,  3, 0, 1};
    vecs[1] = '{1'b1, 1'b0, 0,  1, 1, 0, 0,  2,  4, 0, 1};
    vecs[2] = '{1'b0, 1'b1, 0,  0, 0, 1, 1,  1,  4, 0, 1};
    vecs[3] = '{1'b1, 1'b1, 0,  0, 1, 1, 1,  1,  4, 0, 1};
    vecs[4] = '{1'b1, 1'b0, 10, 0, 1, 0, 0,  1, 12, 0, 1};
    vecs[5] = '{1'b0, 1'b1, 3,  2, 0, 1, 1,  3,  8, 0, 1};
    vecs[6] = '{1'b1, 1'b0, 0, 15, 1, 0, 0, 16, 18, 0, 1};
    vecs[7] = '{1'b1, 1'b0, 0, -1, 1, 0, 0, 16, 18, 1, 0};
    vecs[8] = '{1'b0, 1'b1, 0, -1, 0, 1, 0, 16, 18, 1, 0};
    vecs[9] = '{1'b1, 1'b1, 2,  4, 1, 1, 1,  5,  9, 0, 1};

    repeat (2) @(negedge clk_i);
    chk("rst fence_ack", fence_ack_o, 0);
    chk("rst fence_i_ack", fence_i_ack_o, 0);
    chk("rst dflush", dcache_flush_o, 0);
    chk("rst iflush", icache_flush_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst timeout", timeout_o, 0);
    chk("rst flush_cnt", flush_cnt_o, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // enough plain fences to wrap the 4-bit counter
    w = '{1'b1, 1'b0, 0, 0, 1, 0, 0, 1, 3, 0, 1};
    for (int i = 0; i < 10; i++) run_job(w, $sformatf("wrap%0d", i));

    // flush ack outside FLUSH_D is ignored (IDLE, then WAIT_WB)
    @(negedge clk_i); dcache_flush_ack_i = 1'b1;
    @(negedge clk_i); dcache_flush_ack_i = 1'b0;
    chk("idle_ack busy", busy_o, 0);
    chk("idle_ack cnt", flush_cnt_o, cnt_model);
    fence_req_i = 1'b1; wbuffer_empty_i = 1'b0;
    @(negedge clk_i); dcache_flush_ack_i = 1'b1;
    @(negedge clk_i); dcache_flush_ack_i = 1'b0;
    chk("wb_ack dflush", dcache_flush_o, 0);
    chk("wb_ack busy", busy_o, 1);
    chk("wb_ack cnt", flush_cnt_o, cnt_model);
    wbuffer_empty_i = 1'b1;
    for (int k = 0; k < 10 && !dcache_flush_o; k++) @(negedge clk_i);
    chk("wb_ack dflush_seen", dcache_flush_o, 1);
    dcache_flush_ack_i = 1'b1;
    @(negedge clk_i); dcache_flush_ack_i = 1'b0;
    chk("wb_ack fence_ack", fence_ack_o, 1);
    fence_req_i = 1'b0;
    cnt_model = cnt_model + 1'b1;
    chk("wb_ack cnt_after", flush_cnt_o, cnt_model);

    // fence arriving during a fence.i job waits for its own turn
    @(negedge clk_i); fence_i_req_i = 1'b1;
    for (int k = 0; k < 10 && !dcache_flush_o; k++) @(negedge clk_i);
    chk("late dflush_seen", dcache_flush_o, 1);
    fence_req_i = 1'b1; dcache_flush_ack_i = 1'b1;
    @(negedge clk_i); dcache_flush_ack_i = 1'b0;
    chk("late icache", icache_flush_o, 1);
    @(negedge clk_i);
    chk("late fence_i_ack", fence_i_ack_o, 1);
    chk("late fence_ack_held", fence_ack_o, 0);
    fence_i_req_i = 1'b0;
    cnt_model = cnt_model + 1'b1;
    @(negedge clk_i);
    chk("late back_to_idle", busy_o, 0);
    for (int k = 0; k < 10 && !dcache_flush_o; k++) @(negedge clk_i);
    chk("late dflush2_seen", dcache_flush_o, 1);
    dcache_flush_ack_i = 1'b1;
    @(negedge clk_i); dcache_flush_ack_i = 1'b0;
    chk("late fence_ack", fence_ack_o, 1);
    chk("late fence_i_ack_none", fence_i_ack_o, 0);
    fence_req_i = 1'b0;
    cnt_model = cnt_model + 1'b1;
    chk("late cnt", flush_cnt_o, cnt_model);

    // reset in the middle of FLUSH_D abandons the job silently
    @(negedge clk_i); fence_req_i = 1'b1;
    for (int k = 0; k < 10 && !dcache_flush_o; k++) @(negedge clk_i);
    chk("rstmid dflush_seen", dcache_flush_o, 1);
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstmid dflush", dcache_flush_o, 0);
    chk("rstmid busy", busy_o, 0);
    chk("rstmid cnt", flush_cnt_o, 0);
    chk("rstmid timeout", timeout_o, 0);
    fence_req_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    acks = 0; busies = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (fence_ack_o || fence_i_ack_o) acks++;
      if (busy_o) busies++;
    end
    chk("rstmid no_ack", acks, 0);
    chk("rstmid stays_idle", busies, 0);
    chk("rstmid cnt_after", flush_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
